// File: rtl/fir_cap_pkg.sv
// Shared definitions for fir_response_capture: capture FSM encoding, default
// sizes and the sample magnitude helper.
package fir_cap_pkg;

  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 32;
  localparam int MAG_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // Callers sign-extend into MAG_W and truncate back to DW, so -2^(DW-1)
  // lands on the unsigned value 2^(DW-1) without saturating.
  function automatic logic [MAG_W-1:0] cap_mag(input logic signed [MAG_W-1:0] x);
    logic [MAG_W-1:0] r;
    r = x[MAG_W-1] ? $unsigned(-x) : $unsigned(x);
    return r;
  endfunction

endpackage

// File: rtl/fir_cap_ram.sv
// Capture buffer: DEPTH x DW simple dual-port RAM, synchronous write port and
// registered read port (read register clears on reset, array does not).
module fir_cap_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_response_capture.sv
// Trigger-and-capture consumer for the FIR output with peak/sum statistics and
// a readback port. Define FIR_CAP_AUTOTRIG_EN to force a trigger after TIMEOUT
// valid samples in ARMED.
//
//   state   | meaning
//   IDLE    | after reset, nothing captured
//   ARMED   | waiting for |y_in| >= thresh
//   CAPTURE | writing valid samples at index 1..DEPTH-1
//   DONE    | results stable, readback enabled
module fir_response_capture
  import fir_cap_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] y_in,
  input  logic                 y_valid,
  input  logic                 arm,
  input  logic [DW-1:0]        thresh,
  input  logic                 rd_req,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] peak,
  output logic [AW-1:0]        peak_idx,
  output logic signed [DW+AW-1:0] sum,
  output logic                 timed_out
);

  cap_state_e              state_q;
  logic [AW-1:0]           cnt_q;
  logic                    busy_q, done_q, rd_valid_q;
  logic signed [DW-1:0]    peak_q, peak_d;
  logic [AW-1:0]           peak_idx_q, peak_idx_d;
  logic signed [DW+AW-1:0] sum_q, sum_d;

  logic [DW-1:0]           y_mag, pk_mag;
  logic signed [DW+AW-1:0] y_ext;
  logic                    arm_ok, trig, force_trig, start, wr_en, rd_en;
  logic [AW-1:0]           wr_addr;
  logic [DW-1:0]           ram_rdata;

  assign y_mag  = DW'(cap_mag(MAG_W'(y_in)));
  assign pk_mag = DW'(cap_mag(MAG_W'(peak_q)));
  assign y_ext  = (DW+AW)'(y_in);

`ifdef FIR_CAP_AUTOTRIG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q;
  logic          timed_out_q;

  assign force_trig = (state_q == ST_ARMED) && !arm && y_valid && !trig && (to_cnt_q == '0);
  assign timed_out  = timed_out_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign force_trig     = 1'b0;
  assign timed_out      = 1'b0;
`endif

  // An arm in ARMED restarts the wait, so it masks a coincident trigger.
  assign arm_ok  = arm && (state_q != ST_CAPTURE);
  assign trig    = y_valid && (y_mag >= thresh);
  assign start   = (state_q == ST_ARMED) && !arm && (trig || force_trig);
  assign wr_en   = start || ((state_q == ST_CAPTURE) && y_valid);
  assign wr_addr = start ? '0 : cnt_q;
  assign rd_en   = rd_req && (state_q == ST_DONE) && !arm;

  always_comb begin
    peak_d     = peak_q;
    peak_idx_d = peak_idx_q;
    sum_d      = sum_q;
    if (start) begin
      peak_d     = y_in;
      peak_idx_d = '0;
      sum_d      = y_ext;
    end else if (wr_en) begin
      sum_d = sum_q + y_ext;
      if (y_mag > pk_mag) begin
        peak_d     = y_in;
        peak_idx_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      peak_q      <= '0;
      peak_idx_q  <= '0;
      sum_q       <= '0;
`ifdef FIR_CAP_AUTOTRIG_EN
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      rd_valid_q <= rd_en;
      if (arm_ok) begin
        state_q    <= ST_ARMED;
        cnt_q      <= '0;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        peak_q     <= '0;
        peak_idx_q <= '0;
        sum_q      <= '0;
`ifdef FIR_CAP_AUTOTRIG_EN
        to_cnt_q    <= TW'(TIMEOUT - 1);
        timed_out_q <= 1'b0;
`endif
      end else begin
        peak_q     <= peak_d;
        peak_idx_q <= peak_idx_d;
        sum_q      <= sum_d;
        unique case (state_q)
          ST_ARMED: begin
            if (start) begin
              state_q <= ST_CAPTURE;
              cnt_q   <= AW'(1);
`ifdef FIR_CAP_AUTOTRIG_EN
              timed_out_q <= force_trig;
            end else if (y_valid && (to_cnt_q != '0)) begin
              to_cnt_q <= to_cnt_q - 1'b1;
`endif
            end
          end
          ST_CAPTURE: begin
            if (y_valid) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == AW'(DEPTH - 1)) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  fir_cap_ram #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (wr_en),
    .waddr_i(wr_addr),
    .wdata_i(y_in),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(ram_rdata)
  );

  assign rd_data  = ram_rdata;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign peak     = peak_q;
  assign peak_idx = peak_idx_q;
  assign sum      = sum_q;

endmodule

// File: tb/tb_fir_response_capture.sv
// Bench for fir_response_capture: directed capture scenarios, readback words
// checked through an expected-value queue.
module tb_fir_response_capture;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic signed [DW-1:0]    y_in;
  logic                    y_valid;
  logic                    arm;
  logic [DW-1:0]           thresh;
  logic                    rd_req;
  logic [AW-1:0]           rd_addr;
  logic signed [DW-1:0]    rd_data;
  logic                    rd_valid;
  logic                    busy;
  logic                    done;
  logic signed [DW-1:0]    peak;
  logic [AW-1:0]           peak_idx;
  logic signed [DW+AW-1:0] sum;
  logic                    timed_out;

  fir_response_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .y_in     (y_in),
    .y_valid  (y_valid),
    .arm      (arm),
    .thresh   (thresh),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .done     (done),
    .peak     (peak),
    .peak_idx (peak_idx),
    .sum      (sum),
    .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  int     n_rd  = 0;
  longint exp_q[$];
  logic signed [DW-1:0] exp_buf [DEPTH];
  logic signed [DW-1:0] neg_max = 16'sh8000;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rd_valid === 1'b1) begin
      n_rd++;
      if (exp_q.size() == 0) chk("rd_spurious", rd_valid, 0);
      else                   chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic signed [DW-1:0] v, input logic vld);
    y_in    = v;
    y_valid = vld;
    step();
    y_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [DW-1:0] th);
    thresh = th;
    arm    = 1'b1;
    step();
    arm    = 1'b0;
  endtask

  task automatic fill_buf(input logic signed [DW-1:0] w0, input logic signed [DW-1:0] wrest);
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = (i == 0) ? w0 : wrest;
  endtask

  task automatic read_all(input string tag);
    int base;
    base = n_rd;
    for (int i = 0; i < DEPTH; i++) begin
      rd_req  = 1'b1;
      rd_addr = AW'(i);
      exp_q.push_back(exp_buf[i]);
      step();
    end
    rd_req = 1'b0;
    step();
    step();
    chk({tag, "_rd_count"}, n_rd - base, DEPTH);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    y_in = '0; y_valid = 1'b0; arm = 1'b0; thresh = '0; rd_req = 1'b0; rd_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_peak", peak, 0);
    chk("rst_peak_idx", peak_idx, 0);
    chk("rst_sum", sum, 0);
    chk("rst_timed_out", timed_out, 0);
    rst_n = 1'b1;
    step();

    // reset in the middle of a capture
    do_arm('0);
    for (int i = 0; i < 10; i++) feed(DW'(i + 1), 1'b1);
    chk("mid_busy_pre", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_peak", peak, 0);
    step();
    rst_n = 1'b1;
    step();
    do_arm('0);
    for (int i = 0; i < DEPTH; i++) begin
      feed(DW'(100 + i), 1'b1);
      exp_buf[i] = DW'(100 + i);
    end
    chk("rearm_done", done, 1);
    chk("rearm_sum", sum, 3696);
    chk("rearm_peak", peak, 131);
    chk("rearm_peak_idx", peak_idx, 31);
    read_all("rearm");

    // impulse
    do_arm(16'd1000);
    feed('0, 1'b1);
    chk("imp_not_trig", busy, 1);
    feed(16'sd20000, 1'b1);
    for (int i = 0; i < 30; i++) feed('0, 1'b1);
    chk("imp_done_early", done, 0);
    feed('0, 1'b1);
    chk("imp_done", done, 1);
    chk("imp_busy", busy, 0);
    chk("imp_peak", peak, 20000);
    chk("imp_peak_idx", peak_idx, 0);
    chk("imp_sum", sum, 20000);
    fill_buf(16'sd20000, '0);
    read_all("imp");

    // step, tie rule keeps first index
    do_arm(16'd5000);
    for (int i = 0; i < 40; i++) feed(16'sd10000, 1'b1);
    chk("step_done", done, 1);
    chk("step_sum", sum, 320000);
    chk("step_peak", peak, 10000);
    chk("step_peak_idx", peak_idx, 0);
    fill_buf(16'sd10000, 16'sd10000);
    read_all("step");

    // most negative sample, valid every other cycle
    do_arm(16'h8000);
    for (int c = 0; c < 62; c++) feed(neg_max, (c % 2) == 0);
    chk("neg_done_early", done, 0);
    feed(neg_max, 1'b1);
    chk("neg_done", done, 1);
    chk("neg_peak", peak, -32768);
    chk("neg_peak_idx", peak_idx, 0);
    chk("neg_sum", sum, -1048576);
    fill_buf(neg_max, neg_max);
    read_all("neg");

    // arm together with rd_req in DONE
    thresh  = '0;
    rd_req  = 1'b1;
    rd_addr = AW'(3);
    arm     = 1'b1;
    step();
    rd_req = 1'b0;
    arm    = 1'b0;
    chk("col_rd_valid", rd_valid, 0);
    chk("col_busy", busy, 1);
    chk("col_done", done, 0);
    chk("col_sum_clr", sum, 0);
    chk("col_peak_clr", peak, 0);

    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("armed_rd_valid", rd_valid, 0);

    // arm in ARMED masks the coincident trigger
    y_in = 16'sd5; y_valid = 1'b1; arm = 1'b1;
    step();
    arm = 1'b0; y_valid = 1'b0;
    chk("rearm_trig_busy", busy, 1);
    chk("rearm_trig_sum", sum, 0);
    for (int i = 0; i < 5; i++) feed(16'sd1, 1'b1);
    // arm in CAPTURE is ignored, sample still captured at index 5
    y_in = 16'sd3; y_valid = 1'b1; arm = 1'b1;
    step();
    arm = 1'b0; y_valid = 1'b0;
    chk("capt_arm_busy", busy, 1);
    for (int i = 0; i < 25; i++) feed(16'sd1, 1'b1);
    chk("capt_arm_done_early", done, 0);
    feed(16'sd1, 1'b1);
    chk("capt_arm_done", done, 1);
    chk("capt_arm_sum", sum, 34);
    chk("capt_arm_peak", peak, 3);
    chk("capt_arm_peak_idx", peak_idx, 5);
    chk("capt_arm_timed_out", timed_out, 0);

`ifdef FIR_CAP_AUTOTRIG_EN
    do_arm(16'd30000);
    for (int i = 0; i < 255; i++) feed(16'sd100, 1'b1);
    chk("to_pre_busy", busy, 1);
    chk("to_pre_timed_out", timed_out, 0);
    chk("to_pre_sum", sum, 0);
    feed(16'sd100, 1'b1);
    chk("to_timed_out", timed_out, 1);
    chk("to_sum_first", sum, 100);
    for (int i = 0; i < 31; i++) feed(16'sd100, 1'b1);
    chk("to_done", done, 1);
    chk("to_sum", sum, 3200);
    chk("to_peak", peak, 100);
    chk("to_peak_idx", peak_idx, 0);
    chk("to_timed_out_hold", timed_out, 1);
    fill_buf(16'sd100, 16'sd100);
    read_all("to");
    do_arm('0);
    chk("to_clear", timed_out, 0);
`else
    do_arm(16'd30000);
    for (int i = 0; i < 1000; i++) feed(16'sd100, 1'b1);
    chk("noto_busy", busy, 1);
    chk("noto_done", done, 0);
    chk("noto_timed_out", timed_out, 0);
`endif

    step();
    chk("end_sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
